// File: rtl/ysyx_22041412_mdu_pkg.sv
// Shared types and constants for the M-extension sequencing controller.
// The YSYX_22041412_SEXT32 macro sign-extends bits [31:0] of a signal to a given width.
package ysyx_22041412_mdu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMulWait,
        StDivWait,
        StDone,
        StDrain
    } mdu_state_e;

    localparam logic [2:0] Func3Mul    = 3'd0;
    localparam logic [2:0] Func3Mulh   = 3'd1;
    localparam logic [2:0] Func3Mulhsu = 3'd2;
    localparam logic [2:0] Func3Mulhu  = 3'd3;
    localparam logic [2:0] Func3Div    = 3'd4;
    localparam logic [2:0] Func3Divu   = 3'd5;
    localparam logic [2:0] Func3Rem    = 3'd6;
    localparam logic [2:0] Func3Remu   = 3'd7;

endpackage

`ifndef YSYX_22041412_SEXT32
`define YSYX_22041412_SEXT32(xlen, v) {{((xlen) - 32){v[31]}}, v[31:0]}
`endif

// File: rtl/ysyx_22041412_mdu_watchdog.sv
// Unit-hang watchdog: counts busy cycles since the last clear and raises a sticky error
// when the count reaches TIMEOUT.
module ysyx_22041412_mdu_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expired,
    output logic err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] Last = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic          err_q;

    // Expiry fires in the TIMEOUT-th busy cycle; err is visible in that same cycle.
    assign expired = busy && (count_q == Last);
    assign err     = err_q | expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (clear) begin
                count_q <= '0;
            end else if (busy && !expired) begin
                count_q <= count_q + 1'b1;
            end
            if (expired) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Sequencer between EX and the multi-cycle multiplier/divider. Optional one-entry result
// cache is enabled by defining YSYX_22041412_MDU_CACHE_EN.
module ysyx_22041412_mdu_ctrl
    import ysyx_22041412_mdu_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_func3,
    input  logic            req_w,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] res_data,
    output logic            mul_start,
    output logic            div_start,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic [2:0]      unit_func3,
    output logic            unit_w,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_result,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_result,
    output logic            err
);

    mdu_state_e      state_q, state_d;
    logic            first_q;
    logic [XLEN-1:0] res_q, res_d;

    logic            accept;
    logic            b_zero;
    logic [XLEN-1:0] dz_result;
    logic            sel_done;
    logic [XLEN-1:0] sel_raw, sel_result;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;
    logic            wd_clear, wd_busy, wd_expired;

    assign accept = (state_q == StIdle) && req_valid && !flush;
    assign b_zero = req_w ? (req_b[31:0] == 32'd0) : (req_b == '0);

    // REM/REMU (func3[1]=1) return the dividend; DIV/DIVU return all ones.
    always_comb begin
        dz_result = '1;
        if (req_func3[1]) begin
            dz_result = req_w ? `YSYX_22041412_SEXT32(XLEN, req_a) : req_a;
        end
    end

    assign sel_done   = unit_func3[2] ? div_done : mul_done;
    assign sel_raw    = unit_func3[2] ? div_result : mul_result;
    assign sel_result = unit_w ? `YSYX_22041412_SEXT32(XLEN, sel_raw) : sel_raw;

    assign wd_clear = (state_q == StIdle) || (state_q == StDone);
    assign wd_busy  = (state_q == StMulWait) || (state_q == StDivWait) || (state_q == StDrain);

    ysyx_22041412_mdu_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .busy   (wd_busy),
        .expired(wd_expired),
        .err    (err)
    );

`ifdef YSYX_22041412_MDU_CACHE_EN
    logic            cache_valid_q;
    logic [2:0]      cache_func3_q;
    logic            cache_w_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_res_q;
    logic            fill_q, fill_d;

    assign cache_hit = cache_valid_q && (cache_func3_q == req_func3) && (cache_w_q == req_w)
                       && (cache_a_q == req_a) && (cache_b_q == req_b);
    assign cache_result = cache_res_q;

    // Only real results are cached: timeouts and cache hits themselves do not refill.
    always_comb begin
        fill_d = 1'b0;
        if (state_d == StDone) begin
            fill_d = (state_q == StIdle) ? !cache_hit : sel_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_func3_q <= '0;
            cache_w_q     <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_res_q   <= '0;
            fill_q        <= 1'b0;
        end else begin
            fill_q <= fill_d;
            if ((state_q == StDone) && fill_q && !flush) begin
                cache_valid_q <= 1'b1;
                cache_func3_q <= unit_func3;
                cache_w_q     <= unit_w;
                cache_a_q     <= unit_a;
                cache_b_q     <= unit_b;
                cache_res_q   <= res_q;
            end
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cache_hit) begin
                        state_d = StDone;
                    end else if (!req_func3[2]) begin
                        state_d = StMulWait;
                    end else if (b_zero) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDivWait;
                    end
                end
            end
            StMulWait, StDivWait: begin
                if (sel_done || wd_expired) begin
                    state_d = flush ? StIdle : StDone;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDone:  state_d = StIdle;
            StDrain: begin
                if (sel_done || wd_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        mul_start = 1'b0;
        div_start = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            StIdle:    stall = accept;
            StMulWait: begin
                stall     = 1'b1;
                mul_start = first_q;
            end
            StDivWait: begin
                stall     = 1'b1;
                div_start = first_q;
            end
            StDone:    res_valid = !flush;
            StDrain:   stall = req_valid;
            default:   ;
        endcase
    end

    // res_data only changes on entry to DONE so it holds otherwise.
    always_comb begin
        res_d = res_q;
        if (state_d == StDone) begin
            if (state_q == StIdle) begin
                res_d = cache_hit ? cache_result : dz_result;
            end else begin
                res_d = sel_done ? sel_result : '0;
            end
        end
    end

    assign res_data = res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            first_q    <= 1'b0;
            res_q      <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_func3 <= '0;
            unit_w     <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            res_q   <= res_d;
            if (accept) begin
                unit_a     <= req_a;
                unit_b     <= req_b;
                unit_func3 <= req_func3;
                unit_w     <= req_w;
            end
        end
    end

endmodule

// File: doc/ysyx_22041412_mdu_ctrl.md
Name: ysyx_22041412_mdu_ctrl

Overview:
Sequencing controller for the multi-cycle multiply and divide units behind the EX-stage ALU.
- Captures one M-extension request from EX and dispatches it to the multiplier or the divider.
- Holds the pipeline stalled until the selected unit completes, then returns one formatted result.
- Handles flush, divide-by-zero fast path, RV64 W-variant sign extension and a unit-hang watchdog.

Parameters:
XLEN, 64, datapath width.
TIMEOUT, 64, max cycles waiting for unit done before err asserts.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  M-extension op present in EX; held until stall drops
req_func3  in  3  RISC-V func3; 0-3 mul family, 4-7 div/rem family
req_w  in  1  RV64 W variant
req_a  in  XLEN  rs1 value
req_b  in  XLEN  rs2 value
flush  in  1  kill current op (branch/trap)
stall  out  1  hold EX stage
res_valid  out  1  one-cycle result strobe
res_data  out  XLEN  result
mul_start  out  1  one-cycle start pulse to multiplier
div_start  out  1  one-cycle start pulse to divider
unit_a  out  XLEN  registered operand A to both units
unit_b  out  XLEN  registered operand B to both units
unit_func3  out  3  registered func3
unit_w  out  1  registered W flag
mul_done  in  1  multiplier result valid pulse
mul_result  in  XLEN  multiplier result
div_done  in  1  divider result valid pulse
div_result  in  XLEN  divider result
err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1): state IDLE; stall=0, res_valid=0, res_data=0, mul_start=0, div_start=0, unit_*=0, err=0, watchdog=0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN.
- IDLE, req_valid=1, flush=0:
  - Register operands, func3 and W flag.
  - stall=1 combinationally in this cycle.
  - Mul family (func3[2]=0) -> MUL_WAIT. Div family (func3[2]=1) with b≠0 -> DIV_WAIT.
  - Divide by zero (b==0, or b[31:0]==0 when W) -> DONE directly, no start pulse.
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = a (W: sext a[31:0]).
- MUL_WAIT/DIV_WAIT:
  - Matching start pulse asserts only in the first cycle of the state.
  - stall=1; watchdog increments each cycle.
  - On the matching done pulse: latch result -> DONE. When W, result = sext(result[31:0]).
  - A done pulse from the non-selected unit is ignored.
  - Watchdog reaching TIMEOUT: err=1 (sticky), res_data=0 -> DONE.
- DONE: res_valid=1 for exactly one cycle; stall=0; always -> IDLE. req_valid in DONE is ignored; it is the same instruction retiring.
- Latency: unit done in cycle k gives res_valid in cycle k+1. Divide-by-zero gives res_valid 1 cycle after capture.
- flush:
  - In IDLE: request not captured.
  - In WAIT with no done pulse the same cycle: -> DRAIN.
  - In WAIT with done the same cycle: -> IDLE, result discarded.
  - In DONE: res_valid forced 0.
- DRAIN:
  - stall = req_valid.
  - Wait for the outstanding done pulse, or for the watchdog (which sets err), then -> IDLE. No result is produced.
- Overflow (most-negative / -1) is the divider's responsibility; it is passed through unchanged.
- res_data holds its last value outside DONE.

Optional Feature:
Macro YSYX_22041412_MDU_CACHE_EN.
- Defined: a one-entry cache holds {func3, w, a, b, result} of the last completed, unflushed op.
- An IDLE request matching all key fields goes straight to DONE with the cached result; no start pulse is issued.
- Cache valid clears on reset.
- Undefined: every request dispatches normally.

Decomposition:
- Shared package/define file: state encodings, func3 constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), sext32 helper macro.
- One natural sub-module: ysyx_22041412_mdu_watchdog (counter, clear, TIMEOUT compare, sticky err).

Test Plan:
- MUL, a=3, b=5, mul_done 4 cycles after mul_start -> stall high 5 cycles; res_valid=1 with res_data=15 exactly 1 cycle after mul_done.
- DIVW, a=0xFFFFFFFF_80000000, b=0 -> no div_start; next cycle res_valid=1, res_data=0xFFFFFFFF_FFFFFFFF.
- REMUW, a=0x1_00000007, b=0 -> res_data=0x00000000_00000007.
- DIV in flight, flush 2 cycles after div_start, div_done 3 cycles later -> no res_valid; state IDLE the cycle after div_done; a following MUL request is accepted.
- MULW, mul_result=0x00000000_80000000 -> res_data=0xFFFFFFFF_80000000.
- TIMEOUT=8, no mul_done -> err=1 in cycle 8 of MUL_WAIT; res_valid next cycle with res_data=0; err stays 1 until rst.
